// File: rtl/mem_responder_pkg.sv
// Shared widths, state encodings and counter width for the memory responder.
// Widths come from SA_WIDTH / D_WIDTH / SL_WIDTH, which are shared with the processor.
`ifndef SA_WIDTH
`define SA_WIDTH 5
`endif
`ifndef D_WIDTH
`define D_WIDTH 32
`endif
`ifndef SL_WIDTH
`define SL_WIDTH 24
`endif

package mem_responder_pkg;

    localparam int MEM_AW    = `SA_WIDTH;
    localparam int MEM_DW    = `D_WIDTH;
    localparam int MEM_DEPTH = `SL_WIDTH;
    localparam int RCNT_W    = 16;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_parity_gen.sv
// Even-parity generator: XOR reduction of one data word.
module parity_gen #(
    parameter int DW = 32
) (
    input  logic [DW-1:0] d,
    output logic          p
);

    assign p = ^d;

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory serving the processor bus, with a host preload port.
// Optional macro MEM_PARITY_EN adds a stored even-parity bit per word and the ParErr output.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH,
    parameter int AW    = MEM_AW,
    parameter int DW    = MEM_DW
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [AW-1:0]     Addr,
    input  logic              RW,
    input  logic              En,
    input  logic [DW-1:0]     WData,
    input  logic              Done,
    input  logic              LdEn,
    input  logic [AW-1:0]     LdAddr,
    input  logic [DW-1:0]     LdData,
    input  logic              LdDone,
    output logic [DW-1:0]     Data,
    output logic              Valid,
    output logic              Ready,
    output logic              AddrErr,
    output logic [RCNT_W-1:0] ReadCnt,
`ifdef MEM_PARITY_EN
    output logic              ParErr,
`endif
    output state_t            dbg_state
);

    // Handshake: a request is taken when En=1 at a rising edge while in SERVE;
    // a read answers with Data/Valid after that same edge, there is no back-pressure.

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    state_t        state;

    logic          rq_in_range;
    logic          ld_in_range;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_word;

    assign rq_in_range = ({1'b0, Addr} < DEPTH_W);
    assign ld_in_range = ({1'b0, LdAddr} < DEPTH_W);
    assign rd_word     = mem[Addr];
    assign dbg_state   = state;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = Addr;
        wr_data = WData;
        if (!Rst) begin
            if (state == ST_LOAD && LdEn && ld_in_range) begin
                wr_en   = 1'b1;
                wr_addr = LdAddr;
                wr_data = LdData;
            end else if (state == ST_SERVE && En && RW && rq_in_range) begin
                wr_en = 1'b1;
            end
        end
    end

    // Memory contents survive Rst, so the array has no reset.
    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

`ifdef MEM_PARITY_EN
    logic mem_par [DEPTH];
    logic wr_par;
    logic rd_par;

    parity_gen #(.DW(DW)) u_par_wr (.d(wr_data), .p(wr_par));
    parity_gen #(.DW(DW)) u_par_rd (.d(rd_word), .p(rd_par));

    always_ff @(posedge Clk) begin
        if (wr_en) mem_par[wr_addr] <= wr_par;
    end
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_LOAD;
            Data    <= '0;
            Valid   <= 1'b0;
            Ready   <= 1'b0;
            AddrErr <= 1'b0;
            ReadCnt <= '0;
`ifdef MEM_PARITY_EN
            ParErr  <= 1'b0;
`endif
        end else begin
            Valid <= 1'b0;
`ifdef MEM_PARITY_EN
            ParErr <= 1'b0;
`endif
            case (state)
                ST_LOAD: begin
                    if (LdEn && !ld_in_range) AddrErr <= 1'b1;
                    if (LdDone) begin
                        state <= ST_SERVE;
                        Ready <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (En) begin
                        if (!rq_in_range) AddrErr <= 1'b1;
                        if (!RW) begin
                            Valid <= 1'b1;
                            Data  <= rq_in_range ? rd_word : '0;
                            if (ReadCnt != '1) ReadCnt <= ReadCnt + 1'b1;
`ifdef MEM_PARITY_EN
                            ParErr <= rq_in_range && (rd_par != mem_par[Addr]);
`endif
                        end
                    end
                    if (Done) begin
                        state <= ST_HALT;
                        Ready <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_LOAD;
                    Ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: load, serve, write/read, out-of-range, halt and reset.
// Build with MEM_PARITY_EN defined to also exercise the parity path.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int AW    = MEM_AW;
    localparam int DW    = MEM_DW;
    localparam int DEPTH = MEM_DEPTH;

    logic              Clk;
    logic              Rst;
    logic [AW-1:0]     Addr;
    logic              RW;
    logic              En;
    logic [DW-1:0]     WData;
    logic              Done;
    logic              LdEn;
    logic [AW-1:0]     LdAddr;
    logic [DW-1:0]     LdData;
    logic              LdDone;
    logic [DW-1:0]     Data;
    logic              Valid;
    logic              Ready;
    logic              AddrErr;
    logic [RCNT_W-1:0] ReadCnt;
`ifdef MEM_PARITY_EN
    logic              ParErr;
`endif
    state_t            dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder dut (
        .Clk(Clk), .Rst(Rst), .Addr(Addr), .RW(RW), .En(En), .WData(WData),
        .Done(Done), .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData), .LdDone(LdDone),
        .Data(Data), .Valid(Valid), .Ready(Ready), .AddrErr(AddrErr), .ReadCnt(ReadCnt),
`ifdef MEM_PARITY_EN
        .ParErr(ParErr),
`endif
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        En = 1'b0; RW = 1'b0; Addr = '0; WData = '0; Done = 1'b0;
        LdEn = 1'b0; LdAddr = '0; LdData = '0; LdDone = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        Rst = 1'b1;
        tick();
        tick();
        Rst = 1'b0;

        // Reset state
        chk("rst_data", Data, 32'h0);
        chk("rst_valid", 32'(Valid), 32'd0);
        chk("rst_ready", 32'(Ready), 32'd0);
        chk("rst_addrerr", 32'(AddrErr), 32'd0);
        chk("rst_readcnt", 32'(ReadCnt), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(ST_LOAD));
`ifdef MEM_PARITY_EN
        chk("rst_parerr", 32'(ParErr), 32'd0);
`endif

        // Read request while loading is ignored
        En = 1'b1; RW = 1'b0; Addr = 5'd0;
        tick();
        idle();
        chk("load_ign_valid", 32'(Valid), 32'd0);
        chk("load_ign_data", Data, 32'h0);
        chk("load_ign_cnt", 32'(ReadCnt), 32'd0);

        // Preload; last load coincides with LdDone
        LdEn = 1'b1; LdAddr = 5'd0; LdData = 32'h2002000A;
        tick();
        LdAddr = 5'd2; LdData = 32'h12345678;
        tick();
        chk("still_load", 32'(dbg_state), 32'(ST_LOAD));
        LdAddr = 5'd1; LdData = 32'h00421020; LdDone = 1'b1;
        tick();
        idle();
        chk("serve_ready", 32'(Ready), 32'd1);
        chk("serve_state", 32'(dbg_state), 32'(ST_SERVE));

        // Back-to-back reads
        En = 1'b1; RW = 1'b0; Addr = 5'd0;
        tick();
        chk("rd0_data", Data, 32'h2002000A);
        chk("rd0_valid", 32'(Valid), 32'd1);
        Addr = 5'd1;
        tick();
        chk("rd1_data", Data, 32'h00421020);
        chk("rd1_valid", 32'(Valid), 32'd1);
`ifdef MEM_PARITY_EN
        chk("rd1_parerr", 32'(ParErr), 32'd0);
`endif
        idle();
        tick();
        chk("hold_valid", 32'(Valid), 32'd0);
        chk("hold_data", Data, 32'h00421020);
        chk("cnt_2", 32'(ReadCnt), 32'd2);

        // Load port is ignored while serving
        LdEn = 1'b1; LdAddr = 5'd0; LdData = 32'hFFFFFFFF;
        tick();
        idle();

        // Write then read
        En = 1'b1; RW = 1'b1; Addr = 5'd3; WData = 32'hDEADBEEF;
        tick();
        chk("wr_valid", 32'(Valid), 32'd0);
        chk("wr_data_hold", Data, 32'h00421020);
        RW = 1'b0; WData = '0;
        tick();
        chk("wr_rd_data", Data, 32'hDEADBEEF);
        chk("wr_rd_valid", 32'(Valid), 32'd1);
        Addr = 5'd0;
        tick();
        chk("ld_ign_serve", Data, 32'h2002000A);
        chk("cnt_4", 32'(ReadCnt), 32'd4);

        // Out-of-range read
        Addr = 5'(DEPTH);
        tick();
        chk("oor_data", Data, 32'h0);
        chk("oor_valid", 32'(Valid), 32'd1);
        chk("oor_err", 32'(AddrErr), 32'd1);
`ifdef MEM_PARITY_EN
        chk("oor_parerr", 32'(ParErr), 32'd0);
`endif
        idle();
        tick();
        chk("oor_sticky", 32'(AddrErr), 32'd1);
        chk("cnt_5", 32'(ReadCnt), 32'd5);

`ifdef MEM_PARITY_EN
        // Corrupt one bit on the read path of a stored word
        force dut.rd_word = 32'h12345679;
        En = 1'b1; RW = 1'b0; Addr = 5'd2;
        tick();
        release dut.rd_word;
        idle();
        chk("par_err", 32'(ParErr), 32'd1);
        chk("par_valid", 32'(Valid), 32'd1);
        tick();
        chk("par_pulse", 32'(ParErr), 32'd0);
`endif

        // Read together with Done: served, then HALT
        En = 1'b1; RW = 1'b0; Addr = 5'd2; Done = 1'b1;
        tick();
        idle();
        chk("done_data", Data, 32'h12345678);
        chk("done_valid", 32'(Valid), 32'd1);
        chk("done_ready", 32'(Ready), 32'd0);
        chk("done_state", 32'(dbg_state), 32'(ST_HALT));

        // Requests ignored in HALT
        En = 1'b1; RW = 1'b0; Addr = 5'd0;
        tick();
        chk("halt_valid", 32'(Valid), 32'd0);
        chk("halt_data", Data, 32'h12345678);
        chk("halt_ready", 32'(Ready), 32'd0);
        chk("halt_err", 32'(AddrErr), 32'd1);

        // Reset out of HALT with a request pending
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        idle();
        chk("rst1_valid", 32'(Valid), 32'd0);
        chk("rst1_state", 32'(dbg_state), 32'(ST_LOAD));
        chk("rst1_err", 32'(AddrErr), 32'd0);
        chk("rst1_cnt", 32'(ReadCnt), 32'd0);

        // Reset in SERVE with a read pending
        LdDone = 1'b1;
        tick();
        idle();
        chk("srv2_ready", 32'(Ready), 32'd1);
        En = 1'b1; RW = 1'b0; Addr = 5'd1; Rst = 1'b1;
        tick();
        Rst = 1'b0;
        idle();
        chk("rst2_valid", 32'(Valid), 32'd0);
        chk("rst2_state", 32'(dbg_state), 32'(ST_LOAD));
        chk("rst2_ready", 32'(Ready), 32'd0);
        chk("rst2_data", Data, 32'h0);

        // Memory survives reset
        LdDone = 1'b1;
        tick();
        idle();
        En = 1'b1; RW = 1'b0; Addr = 5'd0;
        tick();
        idle();
        chk("keep_data", Data, 32'h2002000A);
        chk("keep_valid", 32'(Valid), 32'd1);
        chk("keep_cnt", 32'(ReadCnt), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
